sio_l2_rsp_arb: RTL

- Scheduler in SIO for the eight L2-bank-to-SIO response channels (ctag_vld / 32-bit data / 2-bit parity / ue_err per bank).
- Round-robin grants one bank at a time, holds the grant for a whole response packet, and merges the winner's beats onto one registered outbound stream.
- Downstream space is tracked with a packet credit counter; a bank is granted only when a credit is available.

---
 rtl/sio_l2_rsp_pkg.sv | 19 +
 rtl/sio_l2_rsp_arb_if.sv | 48 ++++
 rtl/sio_rr_arb.sv | 29 ++
 rtl/sio_l2_rsp_arb.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/sio_l2_rsp_pkg.sv
// Shared constants and types for the SIO L2 response scheduler.
// Optional parity checking is enabled by SIO_L2_PAR_CHK_EN.
package sio_l2_rsp_pkg;

    localparam int NUM_BANKS = 8;
    localparam int DATA_W    = 32;
    localparam int PKT_BEATS = 17;
    localparam int CREDITS   = 4;
    localparam int BANK_ID_W = $clog2(NUM_BANKS);
    localparam int CNT_W     = $clog2(PKT_BEATS + 1);
    localparam int CRED_W    = $clog2(CREDITS + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        XFER
    } state_e;

endpackage

// File: rtl/sio_l2_rsp_arb_if.sv
// Bank-side and outbound signal bundle for sio_l2_rsp_arb.
// par_err ports exist only when SIO_L2_PAR_CHK_EN is defined.
interface sio_l2_rsp_arb_if;
    import sio_l2_rsp_pkg::*;

    logic [NUM_BANKS-1:0]        l2b_req;
    logic [NUM_BANKS-1:0]        sio_l2b_gnt;
    logic [NUM_BANKS-1:0]        l2b_vld;
    logic [NUM_BANKS*DATA_W-1:0] l2b_data;
    logic [NUM_BANKS*2-1:0]      l2b_parity;
    logic [NUM_BANKS-1:0]        l2b_ue_err;
    logic                        out_vld;
    logic                        out_sop;
    logic                        out_eop;
    logic [BANK_ID_W-1:0]        out_bank;
    logic [DATA_W-1:0]           out_data;
    logic                        out_ue_err;
    logic                        credit_ret;
    logic [CRED_W-1:0]           credit_cnt;
    logic                        proto_err;
`ifdef SIO_L2_PAR_CHK_EN
    logic                        par_err;
    logic                        par_err_sticky;
`endif

    modport slave (
        input  l2b_req, l2b_vld, l2b_data, l2b_parity,
        input  l2b_ue_err, credit_ret,
        output sio_l2b_gnt, out_vld, out_sop, out_eop,
        output out_bank, out_data, out_ue_err,
        output credit_cnt, proto_err
`ifdef SIO_L2_PAR_CHK_EN
        , output par_err, par_err_sticky
`endif
    );

    modport master (
        output l2b_req, l2b_vld, l2b_data, l2b_parity,
        output l2b_ue_err, credit_ret,
        input  sio_l2b_gnt, out_vld, out_sop, out_eop,
        input  out_bank, out_data, out_ue_err,
        input  credit_cnt, proto_err
`ifdef SIO_L2_PAR_CHK_EN
        , input par_err, par_err_sticky
`endif
    );

endinterface

// File: rtl/sio_rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr_i.
module sio_rr_arb
    import sio_l2_rsp_pkg::*;
(
    input  logic [NUM_BANKS-1:0] req_i,
    input  logic [BANK_ID_W-1:0] ptr_i,
    output logic [NUM_BANKS-1:0] gnt_o,
    output logic [BANK_ID_W-1:0] id_o,
    output logic                 vld_o
);

    logic [BANK_ID_W-1:0] idx;

    always_comb begin
        gnt_o = '0;
        id_o  = '0;
        vld_o = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            idx = ptr_i + BANK_ID_W'(i);
            if (!vld_o && req_i[idx]) begin
                vld_o      = 1'b1;
                id_o       = idx;
                gnt_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sio_l2_rsp_arb.sv
// Grants one L2 bank per packet and merges its beats onto a registered stream.
// Define SIO_L2_PAR_CHK_EN to check half-word parity of forwarded beats.
module sio_l2_rsp_arb
    import sio_l2_rsp_pkg::*;
(
    input logic             iol2clk,
    input logic             rst,
    sio_l2_rsp_arb_if.slave bus
);

    state_e               state_q;
    logic [BANK_ID_W-1:0] ptr_q;
    logic [BANK_ID_W-1:0] bank_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [CRED_W-1:0]    cred_q;
    logic [CRED_W-1:0]    cred_d;
    logic [NUM_BANKS-1:0] gnt_q;
    logic                 ue_acc_q;
    logic                 proto_q;
    logic                 out_vld_q;
    logic                 out_sop_q;
    logic                 out_eop_q;
    logic                 out_ue_q;
    logic [BANK_ID_W-1:0] out_bank_q;
    logic [DATA_W-1:0]    out_data_q;

    logic [NUM_BANKS-1:0] pick_oh;
    logic [BANK_ID_W-1:0] pick_id;
    logic                 pick_vld;
    logic [NUM_BANKS-1:0] bank_oh;
    logic [DATA_W-1:0]    beat_data;
    logic                 own_vld;
    logic                 accept;
    logic                 sop;
    logic                 eop;
    logic                 do_gnt;
    logic                 foreign;
    logic                 gap;
    logic                 cred_over;
    logic                 ue_beat;
    logic                 ue_next;

    sio_rr_arb u_rr (
        .req_i (bus.l2b_req),
        .ptr_i (ptr_q),
        .gnt_o (pick_oh),
        .id_o  (pick_id),
        .vld_o (pick_vld)
    );

    always_comb begin
        bank_oh         = '0;
        bank_oh[bank_q] = 1'b1;
    end

    assign beat_data = bus.l2b_data[bank_q*DATA_W +: DATA_W];
    assign own_vld   = bus.l2b_vld[bank_q];
    assign accept    = (state_q != IDLE) && own_vld;
    assign sop       = (state_q == WAIT) && own_vld;
    assign eop       = (state_q == XFER) && own_vld &&
                       (cnt_q == CNT_W'(PKT_BEATS - 1));
    assign do_gnt    = (state_q == IDLE) && (cred_q != '0) && pick_vld;
    assign foreign   = (state_q == IDLE) ? |bus.l2b_vld
                                         : |(bus.l2b_vld & ~bank_oh);
    assign gap       = (state_q == XFER) && !own_vld;
    assign cred_over = bus.credit_ret && !do_gnt &&
                       (cred_q == CRED_W'(CREDITS));
    assign ue_beat   = bus.l2b_ue_err[bank_q];
    assign ue_next   = sop ? ue_beat : (ue_acc_q | ue_beat);

    // A grant and a returned credit in the same cycle cancel out.
    always_comb begin
        cred_d = cred_q;
        if (do_gnt && !bus.credit_ret)
            cred_d = cred_q - CRED_W'(1);
        else if (bus.credit_ret && !do_gnt && !cred_over)
            cred_d = cred_q + CRED_W'(1);
    end

`ifdef SIO_L2_PAR_CHK_EN
    logic par_bad;
    logic par_err_q;
    logic par_stk_q;

    assign par_bad = accept &&
        ({^beat_data[DATA_W-1:DATA_W/2], ^beat_data[DATA_W/2-1:0]}
         != bus.l2b_parity[bank_q*2 +: 2]);

    always_ff @(posedge iol2clk) begin
        if (rst) begin
            par_err_q <= 1'b0;
            par_stk_q <= 1'b0;
        end else begin
            par_err_q <= par_bad;
            par_stk_q <= par_stk_q | par_bad;
        end
    end

    assign bus.par_err        = par_err_q;
    assign bus.par_err_sticky = par_stk_q;
`else
    logic unused_par;
    assign unused_par = ^bus.l2b_parity;
`endif

    always_ff @(posedge iol2clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            bank_q     <= '0;
            cnt_q      <= '0;
            cred_q     <= CRED_W'(CREDITS);
            gnt_q      <= '0;
            ue_acc_q   <= 1'b0;
            proto_q    <= 1'b0;
            out_vld_q  <= 1'b0;
            out_sop_q  <= 1'b0;
            out_eop_q  <= 1'b0;
            out_ue_q   <= 1'b0;
            out_bank_q <= '0;
            out_data_q <= '0;
        end else begin
            gnt_q      <= '0;
            cred_q     <= cred_d;
            out_vld_q  <= accept;
            out_sop_q  <= sop;
            out_eop_q  <= eop;
            out_ue_q   <= eop && ue_next;
            out_bank_q <= accept ? bank_q : '0;
            out_data_q <= accept ? beat_data : '0;
            if (foreign || gap || cred_over)
                proto_q <= 1'b1;
            if (accept)
                ue_acc_q <= ue_next;
            unique case (state_q)
                IDLE: if (do_gnt) begin
                    gnt_q   <= pick_oh;
                    bank_q  <= pick_id;
                    ptr_q   <= pick_id + BANK_ID_W'(1);
                    state_q <= WAIT;
                end
                WAIT: if (own_vld) begin
                    cnt_q   <= CNT_W'(1);
                    state_q <= XFER;
                end
                XFER: if (own_vld) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (eop) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.sio_l2b_gnt = gnt_q;
    assign bus.out_vld     = out_vld_q;
    assign bus.out_sop     = out_sop_q;
    assign bus.out_eop     = out_eop_q;
    assign bus.out_bank    = out_bank_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_ue_err  = out_ue_q;
    assign bus.credit_cnt  = cred_q;
    assign bus.proto_err   = proto_q;

endmodule
